dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data memory between the instruction-fetch port (IF) and the
//  load/store port (LS) with round-robin arbitration and a per-port req/valid handshake.
//  Checks alignment, drives the memory's read_write/address/data_in/access_size, and
//  sign/zero-extends load data (the memory zero-extends). Sits between the core and dmemory.
// PARAMETERS
//  RESET_PRIO     0  port favoured by the first contested arbitration after reset (0=IF, 1=LS)
//  MISALIGN_TRAP  1  1: misaligned requests are rejected with err; 0: passed to memory unchanged
// PORTS
//  clock          in   1   single clock, all state on posedge
//  reset          in   1   synchronous, active-high
//  if_req         in   1   IF request; if_addr held stable until if_valid
//  if_addr        in   32  IF word address
//  if_valid       out  1   one-cycle response strobe
//  if_rdata       out  32  fetched word, valid with if_valid
//  if_err         out  1   misaligned fetch, valid with if_valid
//  ls_req         in   1   LS request; ls_we/addr/wdata/size/unsigned held stable until ls_valid
//  ls_we          in   1   1 = store, 0 = load
//  ls_addr        in   32  byte address
//  ls_wdata       in   32  store data, LSB-aligned
//  ls_size        in   2   00 byte, 01 half, 10 word, 11 illegal
//  ls_unsigned    in   1   1 = zero-extend load, 0 = sign-extend
//  ls_valid       out  1   one-cycle response strobe (loads and stores)
//  ls_rdata       out  32  extended load data, valid with ls_valid; 0 for stores
//  ls_err         out  1   misaligned or illegal-size access, valid with ls_valid
//  mem_rw         out  1   to memory read_write (1 = write on posedge)
//  mem_addr       out  32  to memory address (passed unchanged; the memory handles the base offset)
//  mem_wdata      out  32  to memory data_in
//  mem_size       out  2   to memory access_size
//  mem_rdata      in   32  from memory data_out (combinational read)
// BEHAVIOUR
//  - FSM states: IDLE, ACCESS, RESP. Reset: state=IDLE, owner=none, last_grant=!RESET_PRIO,
//    all valid/err=0, rdata regs=0.
//  - Arbitration occurs in IDLE and RESP: only one req -> grant it; both -> grant the port
//    not in last_grant. Grant: owner<=port, last_grant<=port, state<=ACCESS. No req ->
//    IDLE (from RESP) or stay in IDLE.
//  - ACCESS (one cycle): mem_* are driven combinationally from the owner's held inputs.
//    IF: rw=0, size=10. LS: rw=ls_we, size=ls_size, wdata=ls_wdata.
//    At the posedge, a store commits in memory, load data is extended and registered,
//    and state<=RESP.
//  - RESP (one cycle): owner's valid=1 with registered rdata/err. Requester must drop req or
//    present a new request in this cycle; req high in RESP is a new request (back-to-back).
//  - Latency: req high before edge E0 -> ACCESS after E0 -> valid high after E1 (2 cycles).
//    Throughput: 1 access per 2 cycles; ports alternate when both are continuously requesting.
//  - Outside ACCESS: mem_rw=0, mem_size=11 (memory outputs 0), mem_addr=0, mem_wdata=0.
//  - Misalignment (MISALIGN_TRAP=1): IF addr[1:0]!=0; LS half with addr[0]=1, word with
//    addr[1:0]!=0, or size=11. Access still occupies ACCESS, but mem_rw=0 and mem_size=11.
//    RESP gives err=1, rdata=0. With MISALIGN_TRAP=0, size=11 still errors.
//  - Extension: byte -> {24{ls_unsigned?0:d[7]},d[7:0]}; half -> {16{ls_unsigned?0:d[15]},
//    d[15:0]}; word unchanged. IF data is never extended.
//  - Reset mid-operation: mem_rw is gated by !reset, so no store commits on the reset edge.
//    Any in-flight response is discarded and not replayed.
//  - Requester input changes during ACCESS are illegal (bench asserts).
// STRUCTURE
//  - Shared header dmem_defs.vh: size codes SZ_B/SZ_H/SZ_W/SZ_X, FSM state encodings, port IDs.
//  - One sub-module, load_extend: combinational (data, size, unsigned) -> 32-bit result.
//    Also reused by the writeback stage.
// TESTING (bench instantiates dmemory behind the arbiter)
//  - LS store word 0xDEADBEEF @0x01000010, then lw -> ls_valid 2 cycles after each req;
//    rdata=0xDEADBEEF, err=0.
//  - Memory byte 0x80 @0x01000020: lb -> 0xFFFFFF80; lbu -> 0x00000080;
//    lh with [0x21]=0x7F -> 0x00007F80.
//  - if_req and ls_req held high from reset with RESET_PRIO=0 -> grants IF,LS,IF,LS;
//    one valid every 2 cycles, no port starved.
//  - ls sw @0x01000002 -> ls_err=1, rdata=0, mem_rw never 1; the word at 0x01000000 is unchanged.
//    if_addr=0x01000001 -> if_err=1.
//  - reset asserted in the ACCESS cycle of a store of 0x12345678 -> target memory unchanged,
//    ls_valid never pulses, state IDLE, mem_size=11.
//  - ls_size=11 with MISALIGN_TRAP=0 -> ls_err=1; store of size 00 writes one byte only,
//    and neighbouring bytes are unchanged.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: access size codes, FSM states,
// port identifiers and the load/store legality rule.
package dmem_arbiter_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_LS = 1'b1
  } port_e;

  // Size 11 is always rejected; alignment is only enforced when trapping is enabled.
  function automatic logic lsRequestBad(input logic [1:0] size, input logic [1:0] addrLow,
                                        input logic trap);
    logic bad;
    bad = (size == SZ_X);
    if (trap) begin
      if (size == SZ_H && addrLow[0]) bad = 1'b1;
      if (size == SZ_W && addrLow != 2'b00) bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of byte and half loads; words pass through unchanged.
// Also reused by the writeback stage.
module load_extend
  import dmem_arbiter_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  output logic [31:0] result_o
);

  always_comb begin
    result_o = data_i;
    case (size_i)
      SZ_B:    result_o = {{24{~uns_i & data_i[7]}}, data_i[7:0]};
      SZ_H:    result_o = {{16{~uns_i & data_i[15]}}, data_i[15:0]};
      default: result_o = data_i;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between instruction
// fetch and load/store, with alignment checking and load data extension.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter bit RESET_PRIO    = 1'b0,
  parameter bit MISALIGN_TRAP = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  input  logic [1:0]  ls_size,
  input  logic        ls_unsigned,
  output logic        ls_valid,
  output logic [31:0] ls_rdata,
  output logic        ls_err,
  output logic        mem_rw,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_size,
  input  logic [31:0] mem_rdata
);

  state_e      state_q, state_d;
  port_e       owner_q, owner_d;
  port_e       lastGrant_q, lastGrant_d;
  logic        grantValid;
  port_e       grantPort;
  logic        ifBad, lsBad;
  logic [31:0] loadExt;

  logic        ifValid_q, ifValid_d;
  logic        ifErr_q, ifErr_d;
  logic [31:0] ifRdata_q, ifRdata_d;
  logic        lsValid_q, lsValid_d;
  logic        lsErr_q, lsErr_d;
  logic [31:0] lsRdata_q, lsRdata_d;

  assign ifBad = MISALIGN_TRAP && (if_addr[1:0] != 2'b00);
  assign lsBad = lsRequestBad(ls_size, ls_addr[1:0], MISALIGN_TRAP);

  load_extend u_load_extend (
    .data_i   (mem_rdata),
    .size_i   (ls_size),
    .uns_i    (ls_unsigned),
    .result_o (loadExt)
  );

  // On contention the port that did not win last time gets the grant.
  always_comb begin
    grantValid = 1'b0;
    grantPort  = PORT_IF;
    if (if_req && ls_req) begin
      grantValid = 1'b1;
      grantPort  = (lastGrant_q == PORT_IF) ? PORT_LS : PORT_IF;
    end else if (if_req) begin
      grantValid = 1'b1;
      grantPort  = PORT_IF;
    end else if (ls_req) begin
      grantValid = 1'b1;
      grantPort  = PORT_LS;
    end
  end

  // Rejected accesses still spend their ACCESS cycle but present size 11 with no write;
  // the write enable is gated by reset so a store cannot land on the reset edge.
  always_comb begin
    mem_rw    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_size  = SZ_X;
    if (state_q == ST_ACCESS) begin
      if (owner_q == PORT_IF) begin
        mem_addr = if_addr;
        if (!ifBad) mem_size = SZ_W;
      end else begin
        mem_addr  = ls_addr;
        mem_wdata = ls_wdata;
        if (!lsBad) begin
          mem_size = ls_size;
          mem_rw   = ls_we & ~reset;
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    lastGrant_d = lastGrant_q;
    ifValid_d   = 1'b0;
    ifErr_d     = ifErr_q;
    ifRdata_d   = ifRdata_q;
    lsValid_d   = 1'b0;
    lsErr_d     = lsErr_q;
    lsRdata_d   = lsRdata_q;
    case (state_q)
      ST_ACCESS: begin
        state_d = ST_RESP;
        if (owner_q == PORT_IF) begin
          ifValid_d = 1'b1;
          ifErr_d   = ifBad;
          ifRdata_d = ifBad ? '0 : mem_rdata;
        end else begin
          lsValid_d = 1'b1;
          lsErr_d   = lsBad;
          lsRdata_d = (lsBad || ls_we) ? '0 : loadExt;
        end
      end
      default: begin
        state_d = ST_IDLE;
        if (grantValid) begin
          state_d     = ST_ACCESS;
          owner_d     = grantPort;
          lastGrant_d = grantPort;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= PORT_IF;
      lastGrant_q <= RESET_PRIO ? PORT_IF : PORT_LS;
      ifValid_q   <= 1'b0;
      ifErr_q     <= 1'b0;
      ifRdata_q   <= '0;
      lsValid_q   <= 1'b0;
      lsErr_q     <= 1'b0;
      lsRdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      lastGrant_q <= lastGrant_d;
      ifValid_q   <= ifValid_d;
      ifErr_q     <= ifErr_d;
      ifRdata_q   <= ifRdata_d;
      lsValid_q   <= lsValid_d;
      lsErr_q     <= lsErr_d;
      lsRdata_q   <= lsRdata_d;
    end
  end

  assign if_valid = ifValid_q;
  assign if_err   = ifErr_q;
  assign if_rdata = ifRdata_q;
  assign ls_valid = lsValid_q;
  assign ls_err   = lsErr_q;
  assign ls_rdata = lsRdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (trapping and non-trapping) each behind a
// behavioural byte-addressed memory, checked against a byte-array reference model.
module tb_dmem_arbiter;

  localparam logic [31:0] BASE       = 32'h0100_0000;
  localparam int          MEMBYTES   = 4096;
  localparam bit          RESET_PRIO = 1'b0;

  logic        clock, reset, preload;
  logic        ifReq, lsReq, lsWe, lsUns;
  logic [31:0] ifAddr, lsAddr, lsWdata;
  logic [1:0]  lsSize;

  logic        ifValid1, ifErr1, lsValid1, lsErr1, memRw1;
  logic [31:0] ifRdata1, lsRdata1, memAddr1, memWdata1, memRdata1;
  logic [1:0]  memSize1;
  logic        ifValid0, ifErr0, lsValid0, lsErr0, memRw0;
  logic [31:0] ifRdata0, lsRdata0, memAddr0, memWdata0, memRdata0;
  logic [1:0]  memSize0;

  logic [7:0]  mem1 [0:MEMBYTES-1];
  logic [7:0]  mem0 [0:MEMBYTES-1];
  logic [7:0]  refBytes [0:MEMBYTES-1];
  logic [31:0] off1, off0;
  int          writeCount1;
  int          errors, checks;
  logic        lastErr0;

  dmem_arbiter #(.RESET_PRIO(RESET_PRIO), .MISALIGN_TRAP(1'b1)) u_dut1 (
    .clock(clock), .reset(reset),
    .if_req(ifReq), .if_addr(ifAddr), .if_valid(ifValid1), .if_rdata(ifRdata1), .if_err(ifErr1),
    .ls_req(lsReq), .ls_we(lsWe), .ls_addr(lsAddr), .ls_wdata(lsWdata), .ls_size(lsSize),
    .ls_unsigned(lsUns), .ls_valid(lsValid1), .ls_rdata(lsRdata1), .ls_err(lsErr1),
    .mem_rw(memRw1), .mem_addr(memAddr1), .mem_wdata(memWdata1), .mem_size(memSize1),
    .mem_rdata(memRdata1)
  );

  dmem_arbiter #(.RESET_PRIO(RESET_PRIO), .MISALIGN_TRAP(1'b0)) u_dut0 (
    .clock(clock), .reset(reset),
    .if_req(ifReq), .if_addr(ifAddr), .if_valid(ifValid0), .if_rdata(ifRdata0), .if_err(ifErr0),
    .ls_req(lsReq), .ls_we(lsWe), .ls_addr(lsAddr), .ls_wdata(lsWdata), .ls_size(lsSize),
    .ls_unsigned(lsUns), .ls_valid(lsValid0), .ls_rdata(lsRdata0), .ls_err(lsErr0),
    .mem_rw(memRw0), .mem_addr(memAddr0), .mem_wdata(memWdata0), .mem_size(memSize0),
    .mem_rdata(memRdata0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [7:0] patByte(input int i);
    return 8'((i * 37) ^ (i >> 4) ^ 8'h5A);
  endfunction

  // Behavioural dmemory: little-endian, zero-extending combinational read, write on posedge.
  function automatic logic [31:0] memFormat(input logic [31:0] w, input logic [1:0] sz);
    case (sz)
      2'b00:   return {24'h0, w[7:0]};
      2'b01:   return {16'h0, w[15:0]};
      2'b10:   return w;
      default: return 32'h0;
    endcase
  endfunction

  assign off1 = memAddr1 - BASE;
  assign off0 = memAddr0 - BASE;

  always_comb begin
    memRdata1 = '0;
    if (off1 < 32'(MEMBYTES - 3))
      memRdata1 = memFormat({mem1[off1[11:0] + 12'd3], mem1[off1[11:0] + 12'd2],
                             mem1[off1[11:0] + 12'd1], mem1[off1[11:0]]}, memSize1);
  end

  always_comb begin
    memRdata0 = '0;
    if (off0 < 32'(MEMBYTES - 3))
      memRdata0 = memFormat({mem0[off0[11:0] + 12'd3], mem0[off0[11:0] + 12'd2],
                             mem0[off0[11:0] + 12'd1], mem0[off0[11:0]]}, memSize0);
  end

  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < MEMBYTES; i++) mem1[i] <= patByte(i);
    end else if (memRw1) begin
      writeCount1 <= writeCount1 + 1;
      if (off1 < 32'(MEMBYTES - 3)) begin
        mem1[off1[11:0]] <= memWdata1[7:0];
        if (memSize1 != 2'b00) mem1[off1[11:0] + 12'd1] <= memWdata1[15:8];
        if (memSize1 == 2'b10) begin
          mem1[off1[11:0] + 12'd2] <= memWdata1[23:16];
          mem1[off1[11:0] + 12'd3] <= memWdata1[31:24];
        end
      end
    end
  end

  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < MEMBYTES; i++) mem0[i] <= patByte(i);
    end else if (memRw0 && off0 < 32'(MEMBYTES - 3)) begin
      mem0[off0[11:0]] <= memWdata0[7:0];
      if (memSize0 != 2'b00) mem0[off0[11:0] + 12'd1] <= memWdata0[15:8];
      if (memSize0 == 2'b10) begin
        mem0[off0[11:0] + 12'd2] <= memWdata0[23:16];
        mem0[off0[11:0] + 12'd3] <= memWdata0[31:24];
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Reference read: n little-endian bytes, sign-extended from the top byte unless unsigned.
  function automatic logic [31:0] refRead(input logic [31:0] addr, input int n, input bit uns);
    longint v;
    int off;
    off = int'(addr - BASE);
    v = 0;
    for (int k = n - 1; k >= 0; k--) v = (v << 8) | longint'(refBytes[off + k]);
    if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  function automatic bit lsIsBad(input logic [1:0] size, input logic [31:0] addr);
    int n;
    if (size == 2'b11) return 1'b1;
    n = 1 << size;
    return (int'(addr % 32'(n)) != 0);
  endfunction

  function automatic logic [31:0] refWord(input int off);
    return {refBytes[off + 3], refBytes[off + 2], refBytes[off + 1], refBytes[off]};
  endfunction

  task automatic applyLsStimulus(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [1:0] size, input bit uns, input bit strictLat,
                                 output logic [31:0] rdata, output logic err);
    int cycles, n, off;
    bit bad, got;
    logic [31:0] expData;
    bad = lsIsBad(size, addr);
    n = (size == 2'b11) ? 0 : (1 << size);
    expData = (bad || we) ? 32'h0 : refRead(addr, n, uns);
    lsWe = we; lsAddr = addr; lsWdata = wdata; lsSize = size; lsUns = uns; lsReq = 1'b1;
    cycles = 0; got = 1'b0;
    while (!got && cycles < 20) begin
      @(negedge clock);
      cycles++;
      got = lsValid1;
    end
    rdata = lsRdata1; err = lsErr1; lastErr0 = lsErr0;
    lsReq = 1'b0;
    checkOutput("lsValidSeen", 32'(got), 32'd1);
    if (strictLat) checkOutput("lsLatency", 32'(cycles), 32'd2);
    else checkOutput("lsLatencyBound", 32'(cycles >= 2 && cycles <= 4), 32'd1);
    checkOutput("lsErr", 32'(err), 32'(bad));
    checkOutput("lsRdata", rdata, expData);
    if (!bad && we) begin
      off = int'(addr - BASE);
      for (int k = 0; k < n; k++) refBytes[off + k] = wdata[8*k +: 8];
    end
  endtask

  task automatic applyIfStimulus(input logic [31:0] addr, input bit strictLat,
                                 output logic [31:0] rdata, output logic err);
    int cycles;
    bit bad, got;
    logic [31:0] expData;
    bad = (addr[1:0] != 2'b00);
    expData = bad ? 32'h0 : refRead(addr, 4, 1'b1);
    ifAddr = addr; ifReq = 1'b1;
    cycles = 0; got = 1'b0;
    while (!got && cycles < 20) begin
      @(negedge clock);
      cycles++;
      got = ifValid1;
    end
    rdata = ifRdata1; err = ifErr1;
    ifReq = 1'b0;
    checkOutput("ifValidSeen", 32'(got), 32'd1);
    if (strictLat) checkOutput("ifLatency", 32'(cycles), 32'd2);
    else checkOutput("ifLatencyBound", 32'(cycles >= 2 && cycles <= 4), 32'd1);
    checkOutput("ifErr", 32'(err), 32'(bad));
    checkOutput("ifRdata", rdata, expData);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rd, snap0;
    logic er;
    int wc;
    reset = 1'b1; preload = 1'b1;
    ifReq = 1'b0; ifAddr = '0; lsReq = 1'b0; lsWe = 1'b0; lsAddr = '0; lsWdata = '0;
    lsSize = 2'b10; lsUns = 1'b0; lastErr0 = 1'b0;
    for (int i = 0; i < MEMBYTES; i++) refBytes[i] = patByte(i);
    repeat (2) @(negedge clock);
    preload = 1'b0;
    checkOutput("rstIfValid", 32'(ifValid1), 32'd0);
    checkOutput("rstLsValid", 32'(lsValid1), 32'd0);
    checkOutput("rstLsRdata", lsRdata1, 32'd0);
    checkOutput("rstMemSize", 32'(memSize1), 32'd3);
    checkOutput("rstMemRw", 32'(memRw1), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    applyLsStimulus(1'b1, BASE + 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 1'b1, rd, er);
    applyLsStimulus(1'b0, BASE + 32'h10, 32'h0, 2'b10, 1'b0, 1'b1, rd, er);
    checkOutput("lwLiteral", rd, 32'hDEADBEEF);

    applyLsStimulus(1'b1, BASE + 32'h20, 32'h0000_0080, 2'b00, 1'b0, 1'b1, rd, er);
    applyLsStimulus(1'b1, BASE + 32'h21, 32'h0000_007F, 2'b00, 1'b0, 1'b1, rd, er);
    applyLsStimulus(1'b0, BASE + 32'h20, 32'h0, 2'b00, 1'b0, 1'b1, rd, er);
    checkOutput("lbLiteral", rd, 32'hFFFFFF80);
    applyLsStimulus(1'b0, BASE + 32'h20, 32'h0, 2'b00, 1'b1, 1'b1, rd, er);
    checkOutput("lbuLiteral", rd, 32'h00000080);
    applyLsStimulus(1'b0, BASE + 32'h20, 32'h0, 2'b01, 1'b0, 1'b1, rd, er);
    checkOutput("lhLiteral", rd, 32'h00007F80);

    wc = writeCount1;
    applyLsStimulus(1'b1, BASE + 32'h2, 32'hCAFEF00D, 2'b10, 1'b0, 1'b1, rd, er);
    checkOutput("misSwErr", 32'(er), 32'd1);
    checkOutput("misSwNoWrite", 32'(writeCount1 - wc), 32'd0);
    checkOutput("misSwWord0", {mem1[3], mem1[2], mem1[1], mem1[0]}, refWord(0));
    applyIfStimulus(BASE + 32'h801, 1'b1, rd, er);
    checkOutput("misIfErr", 32'(er), 32'd1);
    applyIfStimulus(BASE + 32'h804, 1'b1, rd, er);

    applyLsStimulus(1'b0, BASE + 32'h50, 32'h0, 2'b11, 1'b0, 1'b1, rd, er);
    checkOutput("sizeXTrap0Err", 32'(lastErr0), 32'd1);
    applyLsStimulus(1'b0, BASE + 32'h21, 32'h0, 2'b01, 1'b0, 1'b1, rd, er);
    checkOutput("misLhTrap0NoErr", 32'(lastErr0), 32'd0);
    snap0 = {mem0[16'h33], mem0[16'h32], mem0[16'h31], mem0[16'h30]};
    applyLsStimulus(1'b1, BASE + 32'h31, 32'hFFFFFFA5, 2'b00, 1'b0, 1'b1, rd, er);
    checkOutput("sbTrap1Word", {mem1[16'h33], mem1[16'h32], mem1[16'h31], mem1[16'h30]}, refWord(32'h30));
    checkOutput("sbTrap0Word", {mem0[16'h33], mem0[16'h32], mem0[16'h31], mem0[16'h30]},
                {snap0[31:16], 8'hA5, snap0[7:0]});

    // Both ports requesting continuously from reset: grant k lands on cycle 2k+2.
    ifAddr = BASE + 32'h808; lsAddr = BASE + 32'h100; lsWe = 1'b0; lsSize = 2'b10; lsUns = 1'b0;
    ifReq = 1'b1; lsReq = 1'b1; reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      bit expIf, expLs;
      @(negedge clock);
      expIf = 1'b0; expLs = 1'b0;
      if (c % 2 == 0) begin
        if (((int'(RESET_PRIO) + c / 2 - 1) % 2) == 0) expIf = 1'b1;
        else expLs = 1'b1;
      end
      checkOutput($sformatf("rrIfValid%0d", c), 32'(ifValid1), 32'(expIf));
      checkOutput($sformatf("rrLsValid%0d", c), 32'(lsValid1), 32'(expLs));
      if (expIf) checkOutput("rrIfRdata", ifRdata1, refRead(ifAddr, 4, 1'b1));
      if (expLs) checkOutput("rrLsRdata", lsRdata1, refRead(lsAddr, 4, 1'b0));
    end
    ifReq = 1'b0; lsReq = 1'b0;
    repeat (2) @(negedge clock);

    // Reset landing in the ACCESS cycle of a store must drop it entirely.
    wc = writeCount1;
    lsWe = 1'b1; lsAddr = BASE + 32'h40; lsWdata = 32'h12345678; lsSize = 2'b10; lsReq = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("rstAccessRw", 32'(memRw1), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("rstGatedRw", 32'(memRw1), 32'd0);
    @(negedge clock);
    lsReq = 1'b0;
    checkOutput("rstNoValidA", 32'(lsValid1), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) begin
      @(negedge clock);
      checkOutput("rstNoValidB", 32'(lsValid1), 32'd0);
      checkOutput("rstIdleSize", 32'(memSize1), 32'd3);
    end
    checkOutput("rstNoWrite", 32'(writeCount1 - wc), 32'd0);
    checkOutput("rstWordKept", {mem1[16'h43], mem1[16'h42], mem1[16'h41], mem1[16'h40]}, refWord(32'h40));

    // Random traffic: IF reads its own region while LS works in a disjoint one.
    fork
      begin
        logic [31:0] r; logic e; logic [31:0] a;
        for (int i = 0; i < 30; i++) begin
          a = BASE + 32'h800 + (32'($urandom_range(0, 255)) << 2);
          if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
          applyIfStimulus(a, 1'b0, r, e);
          repeat ($urandom_range(0, 2)) @(negedge clock);
        end
      end
      begin
        logic [31:0] r; logic e; logic [31:0] a; logic [1:0] sz;
        for (int i = 0; i < 40; i++) begin
          sz = 2'($urandom_range(0, 3));
          a = BASE + 32'h100 + 32'($urandom_range(0, 255));
          if (sz != 2'b11 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
          applyLsStimulus(1'($urandom_range(0, 1)), a, $urandom, sz, 1'($urandom_range(0, 1)),
                          1'b0, r, e);
          repeat ($urandom_range(0, 2)) @(negedge clock);
        end
      end
    join
    for (int k = 32'h100; k < 32'h200; k += 4)
      checkOutput("finalLsRegion", {mem1[k + 3], mem1[k + 2], mem1[k + 1], mem1[k]}, refWord(k));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
